nibble_rr_packer: RTL and testbench
===================================

NIBBLE_RR_PACKER -- requirements
Module: nibble_rr_packer

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; SHALL be a power of two, 2..8.
REQ-002 Parameter NW, default 4, nibble width in bits.
REQ-003 Parameter DEPTH, default 8, nibbles per packed word; SHALL be a power of two, 2..16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request.
REQ-007 data  input  NREQ*NW  requester i nibble at bits [i*NW +: NW].
REQ-008 gnt  output  NREQ  one-hot grant, combinational, zero or one bit set.
REQ-009 word  output  NW*DEPTH  packed word; slot k at bits [k*NW +: NW].
REQ-010 word_valid  output  1  packed word complete and held.
REQ-011 word_ready  input  1  consumer accepts word when word_valid && word_ready.
REQ-012 fill_level  output  clog2(DEPTH)+1  nibbles captured in current word.
REQ-013 last_id  output  clog2(NREQ)  index of most recently granted requester.

Function
REQ-014 Two states: FILL and HOLD; reset state FILL.
REQ-015 Rotating pointer ptr, range 0..NREQ-1, reset 0.
REQ-016 In FILL, gnt SHALL select the first requester with req set, searching ptr, ptr+1, ... mod NREQ; gnt = 0 if req = 0.
REQ-017 In HOLD, gnt SHALL be 0 regardless of req.
REQ-018 On a clock edge with a grant to requester g: slot fill_level of word <= data nibble g; fill_level increments; ptr <= (g+1) mod NREQ; last_id <= g.
REQ-019 Cycles without a grant SHALL leave ptr, fill_level, word and last_id unchanged.
REQ-020 A grant that fills slot DEPTH-1 SHALL move to HOLD; word_valid SHALL be 1 in the following cycle, with fill_level = DEPTH.
REQ-021 In HOLD, word and fill_level SHALL be stable until the handshake.
REQ-022 A HOLD cycle with word_ready = 1 SHALL return to FILL with fill_level <= 0 and word_valid <= 0 next cycle; no grant in that cycle.
REQ-023 word_ready in FILL SHALL be ignored.
REQ-024 Slots not yet overwritten in a new FILL SHALL retain prior values; word is defined only while word_valid = 1.
REQ-025 Minimum period per word: DEPTH grant cycles plus one HOLD cycle.
REQ-026 ptr SHALL wrap from NREQ-1 to 0; fill_level SHALL never exceed DEPTH.

Reset
REQ-027 rst_n low SHALL, immediately and independent of clk: state FILL, ptr 0, fill_level 0, word all-zero, word_valid 0, last_id 0, gnt 0.
REQ-028 Reset asserted mid-word or in HOLD SHALL discard partial/held data with no handshake.
REQ-029 First grant possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package SHALL hold the state enum (FILL, HOLD) and default constants NREQ_DEF = 4, NW_DEF = 4, DEPTH_DEF = 8.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb: inputs req, ptr, enable; output one-hot gnt and encoded index; purely combinational.
REQ-032 Word storage, counter and state register SHALL reside in nibble_rr_packer.

Verification (defaults NREQ 4, NW 4, DEPTH 8)
REQ-033 Reset, then req = 4'b1111 and data = 16'h4321 held constant, word_ready = 0 -> grants 0,1,2,3,0,1,2,3; word = 32'h4321_4321; word_valid = 1 on cycle 9; gnt = 0 while held.
REQ-034 Only req[2] set, data nibble 2 = 4'h5 -> eight consecutive grants to 2; word = 32'h5555_5555; last_id = 2.
REQ-035 In HOLD, word_ready = 0 for 5 cycles then 1 -> word stable for 6 valid cycles; FILL resumes with fill_level = 0 next cycle; first new grant the cycle after that.
REQ-036 ptr = 3, req = 4'b0101 -> grant 0, then 2, then 0 (wrap).
REQ-037 rst_n pulsed low between clock edges after 3 grants -> outputs zero immediately; next word starts at slot 0 with ptr 0.
REQ-038 req = 0 for 10 cycles in FILL mid-word -> no state change; fill_level and word unchanged.

Source files
------------

// File: rtl/nibble_rr_packer_pkg.sv
// Shared types and default sizing for the nibble round-robin packer.
package nibble_rr_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int NW_DEF    = 4;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/nibble_rr_packer_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arb
  import nibble_rr_packer_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] pos;
  logic           found;

  // NREQ is a power of two, so ptr+k wraps naturally in IDW bits.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = ptr + k[IDW-1:0];
      if (enable && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/nibble_rr_packer.sv
// Packs round-robin granted nibbles into a DEPTH-slot word and holds it
// until the consumer handshakes.
module nibble_rr_packer
  import nibble_rr_packer_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NW    = NW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int IDW  = $clog2(NREQ),
  localparam int FLW  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NW-1:0] data,
  output logic [NREQ-1:0]    gnt,
  output logic [NW*DEPTH-1:0] word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [FLW-1:0]     fill_level,
  output logic [IDW-1:0]     last_id
);

  state_t         state, state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           grant_any;
  logic           arb_en;
  logic [NW-1:0]  gnt_nib;
  logic [FLW-2:0] slot;
  logic           last_slot;

  // Grants are suppressed while reset is held so gnt reads zero immediately.
  assign arb_en    = rst_n && (state == FILL);
  assign grant_any = |gnt;
  assign gnt_nib   = data[int'(gnt_idx)*NW +: NW];
  assign slot      = fill_level[FLW-2:0];
  assign last_slot = (fill_level == FLW'(DEPTH - 1));
  assign word_valid = (state == HOLD);

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .enable (arb_en),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: if (grant_any && last_slot) state_next = HOLD;
      HOLD: if (word_ready)             state_next = FILL;
      default:                          state_next = FILL;
    endcase
  end

  // Only a grant or a HOLD handshake touches the datapath; idle cycles keep everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      fill_level <= '0;
      word       <= '0;
      last_id    <= '0;
    end else if (grant_any) begin
      word[int'(slot)*NW +: NW] <= gnt_nib;
      fill_level                <= fill_level + FLW'(1);
      ptr                       <= gnt_idx + IDW'(1);
      last_id                   <= gnt_idx;
    end else if (state == HOLD && word_ready) begin
      fill_level <= '0;
    end
  end

endmodule

// File: tb/tb_nibble_rr_packer.sv
// Directed and random stimulus for nibble_rr_packer against a slot-level
// reference model of the packing rules.
module tb_nibble_rr_packer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  gnt;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  fill_level;
  logic [1:0]  last_id;

  int n_assert = 0;
  int n_fail   = 0;

  int   m_ptr;
  int   m_fill;
  int   m_last;
  bit   m_hold;
  logic [3:0] m_word [8];
  int   exp_g;

  nibble_rr_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill_level (fill_level),
    .last_id    (last_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ptr  = 0;
    m_fill = 0;
    m_last = 0;
    m_hold = 0;
    for (int k = 0; k < 8; k++) m_word[k] = 4'h0;
  endfunction

  function automatic int model_grant(input logic [3:0] r);
    if (m_hold) return -1;
    for (int k = 0; k < 4; k++) begin
      if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    for (int k = 0; k < 8; k++) w[k*4 +: 4] = m_word[k];
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares every output against the model for the inputs currently applied.
  task automatic check_output();
    logic [3:0] eg;
    eg = (exp_g < 0) ? 4'b0000 : (4'b0001 << exp_g);
    check("gnt",        32'(gnt),        32'(eg));
    check("fill_level", 32'(fill_level), 32'(m_fill));
    check("word_valid", 32'(word_valid), 32'(m_hold));
    check("last_id",    32'(last_id),    32'(m_last));
    check("word",       word,            model_word());
  endtask

  // Called at a falling edge: drive, check mid-cycle, clock, update model.
  task automatic apply_stimulus(input logic [3:0] r, input logic [15:0] d, input logic rdy);
    req = r;
    data = d;
    word_ready = rdy;
    #1;
    exp_g = model_grant(r);
    check_output();
    @(posedge clk);
    if (!m_hold) begin
      if (exp_g >= 0) begin
        m_word[m_fill] = d[exp_g*4 +: 4];
        m_fill++;
        m_ptr  = (exp_g + 1) % 4;
        m_last = exp_g;
        if (m_fill == 8) m_hold = 1;
      end
    end else if (rdy) begin
      m_hold = 0;
      m_fill = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    data = 16'h4321;
    word_ready = 1'b0;
    model_reset();
    exp_g = -1;
    #1;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Full fairness sweep with every requester active.
    for (int i = 0; i < 8; i++) apply_stimulus(4'b1111, 16'h4321, 1'b0);
    check("word_4321", word, 32'h4321_4321);
    check("valid_cycle9", 32'(word_valid), 32'd1);

    // Hold for five cycles, then handshake.
    for (int i = 0; i < 5; i++) apply_stimulus(4'b1111, 16'h4321, 1'b0);
    apply_stimulus(4'b1111, 16'h4321, 1'b1);
    check("fill_after_hs", 32'(fill_level), 32'd0);

    // Single requester takes every slot.
    for (int i = 0; i < 8; i++) apply_stimulus(4'b0100, 16'h0500, 1'b0);
    check("word_5555", word, 32'h5555_5555);
    check("last_id_2", 32'(last_id), 32'd2);
    apply_stimulus(4'b0000, 16'h0000, 1'b1);

    // ptr is now 3: wrap to 0, then 2, then 0.
    apply_stimulus(4'b0101, 16'h1234, 1'b0);
    check("wrap_g0", 32'(last_id), 32'd0);
    apply_stimulus(4'b0101, 16'h1234, 1'b0);
    check("wrap_g2", 32'(last_id), 32'd2);
    apply_stimulus(4'b0101, 16'h1234, 1'b0);
    check("wrap_g0b", 32'(last_id), 32'd0);

    // Idle mid-word: nothing moves; ready is ignored in FILL.
    for (int i = 0; i < 10; i++) apply_stimulus(4'b0000, 16'hFFFF, i[0]);
    check("idle_fill", 32'(fill_level), 32'd3);

    // Asynchronous reset between edges discards the partial word.
    #2 rst_n = 1'b0;
    req = 4'b1111;
    #1;
    model_reset();
    exp_g = -1;
    check_output();
    #1 rst_n = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    apply_stimulus(4'b1111, 16'hABCD, 1'b0);
    check("post_rst_slot0", word, 32'h0000_000D);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      apply_stimulus(4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
